// File: rtl/checkdigit_pkg.sv
// Shared types and constants for the ASCII check-digit framer.
package checkdigit_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      DRAIN   = 3'd2,
      EMIT    = 3'd3,
      GAP     = 3'd4
   } framer_state_e;

   // Discard causes reported on err_code alongside frame_err
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SHORT = 2'd1;
   localparam logic [1:0] ERR_LONG  = 2'd2;
   localparam logic [1:0] ERR_CHAR  = 2'd3;

   // Characters the framer recognises
   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_9    = 8'h39;
   localparam logic [7:0] ASC_SP   = 8'h20;
   localparam logic [7:0] ASC_DASH = 8'h2D;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_CR   = 8'h0D;

endpackage

// File: rtl/ascii_digit_classify.sv
// Combinational byte classifier: decimal digit, ignorable filler, or newline.
module ascii_digit_classify
   import checkdigit_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_digit,
   output logic       is_skip,
   output logic       is_lf,
   output logic [3:0] value
);

   // Sort the byte into exactly one class; anything unclassified is illegal
   always_comb begin
      is_digit = 1'b0;
      is_skip  = 1'b0;
      is_lf    = 1'b0;
      value    = 4'd0;
      if ((ch >= ASC_0) && (ch <= ASC_9)) begin
         is_digit = 1'b1;
         value    = ch[3:0];
      end else if ((ch == ASC_SP) || (ch == ASC_DASH) || (ch == ASC_CR)) begin
         is_skip = 1'b1;
      end else if (ch == ASC_LF) begin
         is_lf = 1'b1;
      end else begin
         is_digit = 1'b0;
      end
   end

endmodule

// File: rtl/checkdigit_ascii_framer.sv
// Collects one newline-terminated frame of DIGITS decimal digits from an ASCII
// stream and replays it as a gap-free one-digit-per-cycle burst. Malformed
// frames are dropped up to their newline and reported with a one-cycle pulse.
module checkdigit_ascii_framer
   import checkdigit_pkg::*;
#(
   parameter int DIGITS     = 15,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ascii_valid,
   input  logic [7:0] ascii_data,
   output logic       ascii_ready,
   output logic       dig_valid,
   output logic [3:0] dig_num,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] frames_ok
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
   localparam logic [CW-1:0] IDX_LAST = CW'(DIGITS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   framer_state_e   state_r;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   idx_r;
   logic [GW-1:0]   gap_r;
   logic [1:0]      pend_r;
   logic [3:0]      buf_r [0:DIGITS-1];
   logic            dig_valid_r;
   logic [3:0]      dig_num_r;
   logic            frame_err_r;
   logic [1:0]      err_code_r;
   logic [7:0]      frames_ok_r;

   logic            is_digit_s;
   logic            is_skip_s;
   logic            is_lf_s;
   logic [3:0]      value_s;
   logic            ascii_ready_s;
   logic            xfer_s;
   logic [CW-1:0]   next_idx_s;

   ascii_digit_classify u_classify (
      .ch       (ascii_data),
      .is_digit (is_digit_s),
      .is_skip  (is_skip_s),
      .is_lf    (is_lf_s),
      .value    (value_s)
   );

   // Accept bytes only while assembling or discarding a frame
   always_comb begin
      ascii_ready_s = 1'b0;
      case (state_r)
         COLLECT, DRAIN: ascii_ready_s = 1'b1;
         default:        ascii_ready_s = 1'b0;
      endcase
   end

   assign xfer_s     = ascii_valid & ascii_ready_s;
   assign next_idx_s = idx_r + CW'(1);

   // Framer FSM with digit buffer, burst replay and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         idx_r       <= '0;
         gap_r       <= '0;
         pend_r      <= ERR_NONE;
         for (int i = 0; i < DIGITS; i++) begin
            buf_r[i] <= 4'd0;
         end
         dig_valid_r <= 1'b0;
         dig_num_r   <= 4'd0;
         frame_err_r <= 1'b0;
         err_code_r  <= ERR_NONE;
         frames_ok_r <= 8'd0;
      end else begin
         frame_err_r <= 1'b0;
         err_code_r  <= ERR_NONE;
         case (state_r)
            IDLE: begin
               state_r <= COLLECT;
            end
            COLLECT: begin
               if (xfer_s) begin
                  if (is_digit_s) begin
                     if (cnt_r < CNT_FULL) begin
                        buf_r[cnt_r] <= value_s;
                        cnt_r        <= cnt_r + CW'(1);
                     end else begin
                        pend_r  <= ERR_LONG;
                        state_r <= DRAIN;
                     end
                  end else if (is_lf_s) begin
                     if (cnt_r == CNT_FULL) begin
                        // First digit goes out on the cycle right after the newline
                        idx_r       <= '0;
                        dig_valid_r <= 1'b1;
                        dig_num_r   <= buf_r[0];
                        state_r     <= EMIT;
                     end else begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_SHORT;
                        cnt_r       <= '0;
                     end
                  end else if (is_skip_s) begin
                     state_r <= COLLECT;
                  end else begin
                     pend_r  <= ERR_CHAR;
                     state_r <= DRAIN;
                  end
               end else begin
                  state_r <= COLLECT;
               end
            end
            DRAIN: begin
               // pend_r was set on entry only, so the first cause is kept
               if (xfer_s && is_lf_s) begin
                  frame_err_r <= 1'b1;
                  err_code_r  <= pend_r;
                  pend_r      <= ERR_NONE;
                  cnt_r       <= '0;
                  state_r     <= COLLECT;
               end else begin
                  state_r <= DRAIN;
               end
            end
            EMIT: begin
               if (idx_r == IDX_LAST) begin
                  dig_valid_r <= 1'b0;
                  dig_num_r   <= 4'd0;
                  frames_ok_r <= frames_ok_r + 8'd1;
                  gap_r       <= '0;
                  state_r     <= GAP;
               end else begin
                  idx_r     <= next_idx_s;
                  dig_num_r <= buf_r[next_idx_s];
               end
            end
            GAP: begin
               if (gap_r == GAP_LAST) begin
                  cnt_r   <= '0;
                  state_r <= COLLECT;
               end else begin
                  gap_r <= gap_r + GW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ascii_ready = ascii_ready_s;
   assign dig_valid   = dig_valid_r;
   assign dig_num     = dig_num_r;
   assign frame_err   = frame_err_r;
   assign err_code    = err_code_r;
   assign frames_ok   = frames_ok_r;

endmodule
